// File: rtl/text_blit_controller_pkg.sv
// Shared constants, state encoding and small helpers for the glyph blitter.
// Cell geometry and framebuffer pitch live here so a text-clear block can reuse them.
package text_pkg;

    localparam int CHAR_WIDTH   = 20;
    localparam int CHAR_HEIGHT  = 30;
    localparam int SCREEN_WIDTH = 680;
    localparam int TEXT_TOP     = 240;
    localparam int COLS         = 32;
    localparam int MAX_CHARS    = 240;

    localparam int ADDR_W     = 19;
    localparam int ROM_ADDR_W = 11;
    localparam int INDEX_W    = 8;
    localparam int GLYPH_W    = 6;
    localparam int COUNT_W    = 5;

    localparam logic [7:0] FG_COLOR = 8'hFF;
    localparam logic [7:0] BG_COLOR = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        BASE,
        FETCH,
        WAIT,
        DRAW,
        DONE,
        ERR
    } blit_state_t;

    function automatic logic [ROM_ADDR_W-1:0] romAddress(input logic [GLYPH_W-1:0] glyph,
                                                         input logic [COUNT_W-1:0] row);
        return ROM_ADDR_W'(glyph) * ROM_ADDR_W'(CHAR_HEIGHT) + ROM_ADDR_W'(row);
    endfunction

    // Leftmost pixel is the MSB, so shifting by the column brings it to the top bit.
    function automatic logic [7:0] pixelColor(input logic [CHAR_WIDTH-1:0] bits,
                                              input logic [COUNT_W-1:0] col);
        logic [CHAR_WIDTH-1:0] shifted;
        shifted = bits << col;
        return shifted[CHAR_WIDTH-1] ? FG_COLOR : BG_COLOR;
    endfunction

endpackage

// File: rtl/text_blit_controller_if.sv
// Request, glyph-ROM and framebuffer-write signals of the blitter in one bundle.
// The slave modport is the blitter itself; master is its surroundings.
interface text_blit_controller_if;
    import text_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [INDEX_W-1:0]      req_index;
    logic [GLYPH_W-1:0]      req_glyph;
    logic [ROM_ADDR_W-1:0]   rom_addr;
    logic [CHAR_WIDTH-1:0]   rom_data;
    logic                    fb_we;
    logic [ADDR_W-1:0]       fb_addr;
    logic [7:0]              fb_data;
    logic                    fb_grant;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport slave (
        input  req_valid, req_index, req_glyph, rom_data, fb_grant,
        output req_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );

    modport master (
        output req_valid, req_index, req_glyph, rom_data, fb_grant,
        input  req_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );

endinterface

// File: rtl/text_cell_base.sv
// Combinational map from a text cell index to the pixel address of its top-left corner.
module text_cell_base
    import text_pkg::*;
(
    input  logic [INDEX_W-1:0] index,
    output logic [ADDR_W-1:0]  base
);

    logic [ADDR_W-1:0] line;
    logic [ADDR_W-1:0] column;

    always_comb begin
        line   = ADDR_W'(index) / ADDR_W'(COLS);
        column = ADDR_W'(index) % ADDR_W'(COLS);
        base   = (ADDR_W'(TEXT_TOP) + line * ADDR_W'(CHAR_HEIGHT)) * ADDR_W'(SCREEN_WIDTH)
               + column * ADDR_W'(CHAR_WIDTH);
    end

endmodule

// File: rtl/text_blit_controller.sv
// Draws one glyph into the text region: fetches each ROM row, then writes its
// pixels through the shared framebuffer port, advancing only on arbiter grant.
module text_blit_controller
    import text_pkg::*;
(
    input  logic clock,
    input  logic reset,
    text_blit_controller_if.slave bus
);

    localparam logic [COUNT_W-1:0] LAST_ROW  = COUNT_W'(CHAR_HEIGHT - 1);
    localparam logic [COUNT_W-1:0] LAST_COL  = COUNT_W'(CHAR_WIDTH - 1);
    localparam logic [INDEX_W-1:0] MAX_INDEX = INDEX_W'(MAX_CHARS);

    blit_state_t           state;
    logic [INDEX_W-1:0]    indexReg;
    logic [GLYPH_W-1:0]    glyphReg;
    logic [ADDR_W-1:0]     rowBase;
    logic [ADDR_W-1:0]     cellBase;
    logic [COUNT_W-1:0]    row;
    logic [COUNT_W-1:0]    col;
    logic [CHAR_WIDTH-1:0] rowReg;

    text_cell_base cellMap (
        .index (indexReg),
        .base  (cellBase)
    );

    // rowBase starts at the cell base and steps one pitch per row, so the
    // write address is always rowBase + col without a multiplier in the loop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            indexReg      <= '0;
            glyphReg      <= '0;
            rowBase       <= '0;
            row           <= '0;
            col           <= '0;
            rowReg        <= '0;
            bus.req_ready <= 1'b1;
            bus.rom_addr  <= '0;
            bus.fb_we     <= 1'b0;
            bus.fb_addr   <= '0;
            bus.fb_data   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        indexReg      <= bus.req_index;
                        glyphReg      <= bus.req_glyph;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.req_index < MAX_INDEX) begin
                            state <= BASE;
                        end else begin
                            bus.err <= 1'b1;
                            state   <= ERR;
                        end
                    end
                end
                ERR: begin
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                BASE: begin
                    rowBase      <= cellBase;
                    row          <= '0;
                    bus.rom_addr <= romAddress(glyphReg, '0);
                    state        <= FETCH;
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    rowReg      <= bus.rom_data;
                    col         <= '0;
                    bus.fb_we   <= 1'b1;
                    bus.fb_addr <= rowBase;
                    bus.fb_data <= pixelColor(bus.rom_data, '0);
                    state       <= DRAW;
                end
                DRAW: begin
                    if (bus.fb_grant) begin
                        if (col == LAST_COL) begin
                            bus.fb_we <= 1'b0;
                            if (row == LAST_ROW) begin
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end else begin
                                row          <= row + 1'b1;
                                rowBase      <= rowBase + ADDR_W'(SCREEN_WIDTH);
                                bus.rom_addr <= romAddress(glyphReg, row + 1'b1);
                                state        <= FETCH;
                            end
                        end else begin
                            col         <= col + 1'b1;
                            bus.fb_addr <= bus.fb_addr + ADDR_W'(1);
                            bus.fb_data <= pixelColor(rowReg, col + 1'b1);
                        end
                    end
                end
                DONE: begin
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.fb_we     <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_blit_controller.sv
// Self-checking bench for text_blit_controller: table of single requests plus
// hand-written stall, reset-abort and back-to-back sequences.
module tb_text_blit_controller;
    import text_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   passes = 0;
    int   romMode = 0;
    int   stallStart = -100;

    text_blit_controller_if bus();

    text_blit_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [19:0] romPattern(input logic [10:0] a);
        return {a, ~a[8:0]};
    endfunction

    // Registered glyph ROM: one-cycle latency from rom_addr to rom_data.
    always @(posedge clock)
        bus.rom_data <= (romMode == 0) ? 20'h80001 : romPattern(bus.rom_addr);

    // Arbiter model: grant withheld for five cycles starting at stallStart.
    always @(posedge clock) begin
        #1;
        bus.fb_grant = !(cycle >= stallStart && cycle < stallStart + 5);
    end

    logic [18:0] wrAddr[$];
    logic [7:0]  wrData[$];
    int          wrCycle[$];
    int          weCycles, doneCycle, errCycle, holdBad;
    logic        held;
    logic [18:0] heldAddr;
    logic [7:0]  heldData;

    // Write monitor: records granted writes and flags any change while stalled.
    always @(negedge clock) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (bus.fb_we) weCycles++;
            if (held && bus.fb_we && (bus.fb_addr != heldAddr || bus.fb_data != heldData))
                holdBad++;
            held     = bus.fb_we && !bus.fb_grant;
            heldAddr = bus.fb_addr;
            heldData = bus.fb_data;
            if (bus.fb_we && bus.fb_grant) begin
                wrAddr.push_back(bus.fb_addr);
                wrData.push_back(bus.fb_data);
                wrCycle.push_back(cycle);
            end
            if (bus.done) doneCycle = cycle;
            if (bus.err)  errCycle  = cycle;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic clearMon();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        weCycles  = 0;
        doneCycle = -1;
        errCycle  = -1;
        holdBad   = 0;
    endtask

    function automatic int qAddr(input int k);
        return (wrAddr.size() > k) ? int'(wrAddr[k]) : -1;
    endfunction

    function automatic int qData(input int k);
        return (wrData.size() > k) ? int'(wrData[k]) : -1;
    endfunction

    function automatic int qCycle(input int k);
        return (wrCycle.size() > k) ? wrCycle[k] : -1;
    endfunction

    task automatic applyStimulus(input logic [7:0] idx, input logic [5:0] glyph, output int acceptT);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!bus.req_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (!bus.req_ready) checkOutput("ready_timeout", 0, 1);
        clearMon();
        bus.req_index = idx;
        bus.req_glyph = glyph;
        bus.req_valid = 1'b1;
        acceptT = cycle;
        @(negedge clock);
        bus.req_valid = 1'b0;
        checkOutput("busy_after_accept", bus.busy, 1);
        checkOutput("ready_low_when_busy", bus.req_ready, 0);
    endtask

    task automatic waitFinish(input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            if (bus.done || bus.err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            n++;
        end
        if (!ok) checkOutput("finish_timeout", 0, 1);
        @(negedge clock);
    endtask

    // Compares every granted write of one glyph against the cell geometry and ROM contents.
    task automatic checkSequence(input string tag, input int startPos, input int idx,
                                 input int glyph, input int mode);
        int bad, base, r, c, expAddr;
        logic [19:0] pattern, shifted;
        logic [7:0]  expData;
        bad  = 0;
        base = (240 + (idx / 32) * 30) * 680 + (idx % 32) * 20;
        for (int k = 0; k < 600; k++) begin
            r       = k / 20;
            c       = k % 20;
            expAddr = base + r * 680 + c;
            pattern = (mode == 0) ? 20'h80001 : romPattern(11'(glyph * 30 + r));
            shifted = pattern << c;
            expData = shifted[19] ? 8'hFF : 8'h00;
            if (qAddr(startPos + k) != expAddr || qData(startPos + k) != int'(expData)) bad++;
        end
        checkOutput({tag, "_bad_writes"}, bad, 0);
    endtask

    typedef struct {
        logic [7:0] index;
        logic [5:0] glyph;
        int         mode;
        bit         isErr;
        int         firstAddr;
        int         lastAddr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int T, D, n, doneD;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_glyph = '0;
        bus.fb_grant  = 1'b1;
        clearMon();

        vecs[0] = '{8'd0,   6'd1,  0, 1'b0, 163200, 182939};
        vecs[1] = '{8'd33,  6'd5,  1, 1'b0, 183620, 203359};
        vecs[2] = '{8'd239, 6'd63, 1, 1'b0, 306300, 326039};
        vecs[3] = '{8'd240, 6'd4,  1, 1'b1, 0,      0};
        vecs[4] = '{8'd255, 6'd0,  1, 1'b1, 0,      0};
        vecs[5] = '{8'd31,  6'd0,  1, 1'b0, 163820, 183559};

        repeat (3) @(negedge clock);
        checkOutput("reset_req_ready", bus.req_ready, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_fb_we", bus.fb_we, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_err", bus.err, 0);
        checkOutput("reset_fb_addr", bus.fb_addr, 0);
        checkOutput("reset_rom_addr", bus.rom_addr, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            romMode = vecs[i].mode;
            applyStimulus(vecs[i].index, vecs[i].glyph, T);
            waitFinish(1000);
            if (vecs[i].isErr) begin
                checkOutput($sformatf("v%0d_err_cycle", i), errCycle - T, 1);
                checkOutput($sformatf("v%0d_we_cycles", i), weCycles, 0);
                checkOutput($sformatf("v%0d_ready_cycle", i), cycle - T, 2);
                checkOutput($sformatf("v%0d_ready_again", i), bus.req_ready, 1);
            end else begin
                checkOutput($sformatf("v%0d_write_count", i), wrAddr.size(), 600);
                checkOutput($sformatf("v%0d_we_cycles", i), weCycles, 600);
                checkOutput($sformatf("v%0d_first_addr", i), qAddr(0), vecs[i].firstAddr);
                checkOutput($sformatf("v%0d_last_addr", i), qAddr(599), vecs[i].lastAddr);
                checkOutput($sformatf("v%0d_first_cycle", i), qCycle(0) - T, 4);
                checkOutput($sformatf("v%0d_last_cycle", i), qCycle(599) - T, 661);
                checkOutput($sformatf("v%0d_done_cycle", i), doneCycle - T, 662);
                checkOutput($sformatf("v%0d_ready_cycle", i), cycle - T, 663);
                checkOutput($sformatf("v%0d_ready_again", i), bus.req_ready, 1);
                checkSequence($sformatf("v%0d", i), 0, vecs[i].index, vecs[i].glyph, vecs[i].mode);
                if (i == 0) begin
                    checkOutput("idx0_col0_data", qData(0), 8'hFF);
                    checkOutput("idx0_col1_data", qData(1), 8'h00);
                    checkOutput("idx0_col18_data", qData(18), 8'h00);
                    checkOutput("idx0_col19_addr", qAddr(19), 163219);
                    checkOutput("idx0_col19_data", qData(19), 8'hFF);
                end
                if (i == 1) checkOutput("idx33_row1_col0_addr", qAddr(20), 184300);
            end
        end

        // Five-cycle grant stall in the middle of row 3.
        romMode = 1;
        applyStimulus(8'd33, 6'd2, T);
        stallStart = T + 4 + 22 * 3 + 7;
        waitFinish(1000);
        stallStart = -100;
        checkOutput("stall_write_count", wrAddr.size(), 600);
        checkOutput("stall_we_cycles", weCycles, 605);
        checkOutput("stall_hold_changes", holdBad, 0);
        checkOutput("stall_last_cycle", qCycle(599) - T, 666);
        checkOutput("stall_done_cycle", doneCycle - T, 667);
        checkSequence("stall", 0, 33, 2, 1);

        // Reset during row 10 abandons the cell; a new request then runs normally.
        applyStimulus(8'd100, 6'd7, T);
        n = 0;
        while (cycle < T + 4 + 22 * 10 + 5 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_fb_we", bus.fb_we, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_req_ready", bus.req_ready, 1);
        reset = 1'b0;
        n = wrAddr.size();
        repeat (10) @(negedge clock);
        checkOutput("abort_no_more_writes", wrAddr.size(), n);
        checkOutput("abort_idle_fb_we", bus.fb_we, 0);
        applyStimulus(8'd5, 6'd9, T);
        waitFinish(1000);
        checkOutput("after_abort_write_count", wrAddr.size(), 600);
        checkOutput("after_abort_first_addr", qAddr(0), 163300);
        checkOutput("after_abort_done_cycle", doneCycle - T, 662);
        checkSequence("after_abort", 0, 5, 9, 1);

        // req_valid held high: index changes while busy are ignored, and the
        // next request is taken on the first IDLE cycle.
        romMode = 0;
        @(negedge clock);
        clearMon();
        bus.req_index = 8'd1;
        bus.req_glyph = 6'd2;
        bus.req_valid = 1'b1;
        T = cycle;
        @(negedge clock);
        bus.req_index = 8'd3;
        checkOutput("b2b_busy", bus.busy, 1);
        n = 0;
        while (!bus.done && n < 1000) begin
            @(negedge clock);
            n++;
        end
        D = cycle;
        checkOutput("b2b_first_done_cycle", D - T, 662);
        @(negedge clock);
        checkOutput("b2b_idle_ready", bus.req_ready, 1);
        @(negedge clock);
        checkOutput("b2b_second_accepted", bus.busy, 1);
        bus.req_valid = 1'b0;
        waitFinish(1000);
        doneD = doneCycle;
        checkOutput("b2b_total_writes", wrAddr.size(), 1200);
        checkOutput("b2b_first_op_addr", qAddr(0), 163220);
        checkOutput("b2b_second_op_addr", qAddr(600), 163260);
        checkOutput("b2b_second_first_cycle", qCycle(600) - D, 5);
        checkOutput("b2b_second_done_cycle", doneD - D, 663);
        checkSequence("b2b_first", 0, 1, 2, 0);
        checkSequence("b2b_second", 600, 3, 2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
